// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states and line constants.
// Parity state exists only with FIFO_UART_TX_PARITY_EN defined.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 868;
  localparam int FRAME_BITS_8N1 = 10;
  localparam int FRAME_BITS_8E1 = 11;

  localparam logic TX_IDLE  = 1'b1;
  localparam logic TX_START = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LATCH,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, tick on the last count.
// Shared between the transmit and receive UART blocks.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = enable && (cnt_q == LAST);
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter, 8N1 (8E1 with FIFO_UART_TX_PARITY_EN).
// Pops one byte per frame; tx is registered, one cycle behind state.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd,
  output logic                 tx,
  output logic                 busy
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT =
    BW'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 tick;
  logic                 timed;
  logic                 clear;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign timed = (state_q != IDLE) &&
                 (state_q != REQ) &&
                 (state_q != LATCH);
  assign clear = (state_d != state_q);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .enable(timed),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = TX_IDLE;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) state_d = REQ;
      end
      REQ: begin
        state_d = LATCH;
      end
      LATCH: begin
        shift_d  = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = ^fifo_data;
`endif
        state_d  = START;
      end
      START: begin
        tx_d  = TX_START;
        bit_d = '0;
        if (tick) state_d = DATA;
      end
      DATA: begin
        tx_d = shift_q[0];
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        tx_d = parity_q;
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        tx_d = TX_IDLE;
        if (tick) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= TX_IDLE;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign fifo_rd = (state_q == REQ);
  assign busy    = (state_q != IDLE);
  assign tx      = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4 with a FIFO model.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int BUSY_CYC = NB * CPB + 2;
  localparam int PERIOD   = NB * CPB + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd;
  logic       tx;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] mem [0:255];
  int push_cnt = 0;
  int pop_cnt  = 0;

  logic tx_log   [0:299];
  logic busy_log [0:299];
  logic rd_log   [0:299];

  always #5 clk = ~clk;

  assign fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (fifo_rd && (push_cnt != pop_cnt)) begin
      fifo_data <= mem[pop_cnt % 256];
      pop_cnt   <= pop_cnt + 1;
    end
  end

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .tx        (tx),
    .busy      (busy)
  );

  task automatic push(input logic [7:0] b);
    mem[push_cnt % 256] = b;
    push_cnt = push_cnt + 1;
  endtask

  task automatic capture(input int n, input int drop_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_log[i]   = tx;
      busy_log[i] = busy;
      rd_log[i]   = fifo_rd;
      if (i == drop_at) enable = 1'b0;
    end
  endtask

  // Expected line level of frame bit j (0 = start) for byte b.
  function automatic logic exp_bit(input logic [7:0] b,
                                   input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (NB == 11 && j == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic int count_rd(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (rd_log[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_busy(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (busy_log[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (tx !== 1'b1) begin
      errors++; $display("FAIL reset_tx: got %b want 1", tx);
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    vectors++;
    if (fifo_rd !== 1'b0) begin
      errors++; $display("FAIL reset_rd: got %b want 0", fifo_rd);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int bad;
    enable = 1'b1;
    push(8'hA5);
    capture(21, -1);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: tx=%b busy=%b rd=%b want 1/0/0",
               tx, busy, fifo_rd);
    end
    rst = 1'b0;
    capture(60, -1);
    bad = 0;
    for (int i = 0; i < 60; i++) if (tx_log[i] !== 1'b1) bad++;
    vectors++;
    if (bad != 0 || count_rd(60) != 0) begin
      errors++;
      $display("FAIL mid_reset_quiet: low=%0d rd=%0d want 0/0",
               bad, count_rd(60));
    end
  endtask

  task automatic test_single;
    logic e;
    logic got;
    int bad;
    enable = 1'b1;
    push(8'hA5);
    capture(60, -1);
    vectors++;
    if (rd_log[0] !== 1'b1 || count_rd(60) != 1) begin
      errors++;
      $display("FAIL single_rd: first=%b pulses=%0d want 1/1",
               rd_log[0], count_rd(60));
    end
    vectors++;
    if (tx_log[2] !== 1'b1 || tx_log[3] !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: tx@2=%b tx@3=%b want 1/0",
               tx_log[2], tx_log[3]);
    end
    for (int j = 0; j < NB; j++) begin
      e = exp_bit(8'hA5, j);
      bad = 0;
      got = e;
      for (int c = 0; c < CPB; c++)
        if (tx_log[3 + CPB*j + c] !== e) begin
          bad++; got = tx_log[3 + CPB*j + c];
        end
      vectors++;
      if (bad != 0) begin
        errors++;
        $display("FAIL single_bit%0d: got %b want %b", j, got, e);
      end
    end
    vectors++;
    if (count_busy(60) != BUSY_CYC) begin
      errors++;
      $display("FAIL single_busy: got %0d want %0d",
               count_busy(60), BUSY_CYC);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [0:2];
    logic e;
    int bad;
    int base;
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h3C;
    enable = 1'b1;
    for (int f = 0; f < 3; f++) push(bytes[f]);
    capture(3 * PERIOD + 6, -1);
    for (int f = 0; f < 3; f++) begin
      base = 3 + PERIOD * f;
      bad = 0;
      for (int j = 0; j < NB; j++) begin
        e = exp_bit(bytes[f], j);
        for (int c = 0; c < CPB; c++)
          if (tx_log[base + CPB*j + c] !== e) bad++;
      end
      vectors++;
      if (bad != 0) begin
        errors++;
        $display("FAIL b2b_frame%0d: %0d bad samples want 0",
                 f, bad);
      end
    end
    for (int f = 1; f < 3; f++) begin
      base = PERIOD * f;
      vectors++;
      if (tx_log[base] !== 1'b1 || tx_log[base+1] !== 1'b1 ||
          tx_log[base+2] !== 1'b1 || tx_log[base+3] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_gap%0d: %b%b%b%b want 1110", f,
                 tx_log[base], tx_log[base+1],
                 tx_log[base+2], tx_log[base+3]);
      end
    end
    vectors++;
    if (count_rd(3 * PERIOD + 6) != 3) begin
      errors++;
      $display("FAIL b2b_rd: got %0d want 3",
               count_rd(3 * PERIOD + 6));
    end
    vectors++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_empty: got %b want 1", fifo_empty);
    end
  endtask

  task automatic test_enable;
    logic e;
    int bad;
    enable = 1'b0;
    push(8'h5A);
    push(8'hC3);
    capture(100, -1);
    bad = 0;
    for (int i = 0; i < 100; i++) if (tx_log[i] !== 1'b1) bad++;
    vectors++;
    if (bad != 0 || count_rd(100) != 0) begin
      errors++;
      $display("FAIL en_hold: low=%0d rd=%0d want 0/0",
               bad, count_rd(100));
    end
    enable = 1'b1;
    capture(60, 12);
    bad = 0;
    for (int j = 0; j < NB; j++) begin
      e = exp_bit(8'h5A, j);
      for (int c = 0; c < CPB; c++)
        if (tx_log[3 + CPB*j + c] !== e) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL en_frame: %0d bad samples want 0", bad);
    end
    vectors++;
    if (count_rd(60) != 1 || fifo_empty !== 1'b0) begin
      errors++;
      $display("FAIL en_gate: rd=%0d empty=%b want 1/0",
               count_rd(60), fifo_empty);
    end
    enable = 1'b1;
    capture(60, -1);
    bad = 0;
    for (int j = 0; j < NB; j++) begin
      e = exp_bit(8'hC3, j);
      for (int c = 0; c < CPB; c++)
        if (tx_log[3 + CPB*j + c] !== e) bad++;
    end
    vectors++;
    if (bad != 0 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL en_drain: bad=%0d empty=%b want 0/1",
               bad, fifo_empty);
    end
  endtask

`ifdef FIFO_UART_TX_PARITY_EN
  task automatic test_parity;
    int pb;
    enable = 1'b1;
    pb = 3 + CPB * 9;
    push(8'hA5);
    capture(PERIOD + 4, -1);
    vectors++;
    if (tx_log[pb] !== 1'b0 || tx_log[pb+3] !== 1'b0) begin
      errors++;
      $display("FAIL parity_a5: got %b want 0", tx_log[pb]);
    end
    vectors++;
    if (count_busy(PERIOD + 4) != 46 ||
        tx_log[3 + 44] !== 1'b1 || tx_log[3 + 43] !== 1'b1) begin
      errors++;
      $display("FAIL parity_len: busy=%0d want 46",
               count_busy(PERIOD + 4));
    end
    push(8'h07);
    capture(PERIOD + 4, -1);
    vectors++;
    if (tx_log[pb] !== 1'b1 || tx_log[pb+3] !== 1'b1) begin
      errors++;
      $display("FAIL parity_07: got %b want 1", tx_log[pb]);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_reset_mid;
    test_single;
    test_back_to_back;
    test_enable;
`ifdef FIFO_UART_TX_PARITY_EN
    test_parity;
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream consumer of the 8-deep synchronous byte FIFO. It pops bytes through the FIFO read port and serialises each one onto a UART line: 8N1 by default, 8E1 when the optional feature is compiled in. It sits between the FIFO and the board's TX pin, and drains the FIFO whenever `enable` is high and the FIFO is not empty.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200). Legal range is 2 or more.
- DATA_BITS, 8: payload bits per frame. Fixed to match the FIFO width; any other value is illegal.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when low, no new byte is popped; a frame already in flight still completes.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  8  FIFO registered read data; valid the cycle after fifo_rd.
- fifo_rd  out  1  single-cycle FIFO pop strobe.
- tx  out  1  serial line, idle high, registered.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: tx=1, fifo_rd=0, busy=0, state=IDLE, bit counter=0, cycle counter=0, shift register=0.
- Reset mid-frame: tx returns to 1 on the next edge. The frame is aborted and the popped byte is lost, with no retry.
- FSM states: IDLE, REQ, LATCH, START, DATA, PARITY (feature only), STOP.
- IDLE: if enable=1 and fifo_empty=0, go to REQ; otherwise hold, with tx=1.
- REQ: lasts exactly 1 cycle with fifo_rd=1 (Moore output), then goes to LATCH. fifo_rd is never high in any other state.
- LATCH: lasts 1 cycle. shift_reg<=fifo_data, then go to START.
- Latency: if fifo_empty=0 is sampled in IDLE at edge N, fifo_rd is high during cycle N+1 and tx falls at edge N+3.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: LSB first; each bit is held for CLKS_PER_BIT cycles. Shift right at each bit boundary. The bit index runs 0..7; after bit 7 go to PARITY (if compiled in) or STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Back-to-back frames: IDLE lasts at least 1 cycle between frames, so the minimum frame-to-frame gap is 3 cycles of idle-high beyond the stop bit.
- Cycle counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, and the bit boundary is at CLKS_PER_BIT-1. The counter clears on every state entry; no wrap beyond the terminal value.
- fifo_empty and enable are ignored outside IDLE.
- A FIFO underflow is impossible by construction, because REQ is entered only when fifo_empty=0.
- tx is registered; no combinational path runs from the inputs to tx.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- With the macro defined:
  - PARITY is inserted between DATA and STOP and lasts CLKS_PER_BIT cycles.
  - The parity bit is even: tx = XOR of the 8 data bits.
  - The parity value is computed in LATCH from fifo_data.
  - Frame length is 11 bits.
- Without the macro: the PARITY state and its parity register do not exist, DATA goes directly to STOP, and frame length is 10 bits.

Decomposition:
- Shared package uart_pkg:
  - state enum (state_t);
  - default constant CLKS_PER_BIT_DEFAULT=868;
  - constants FRAME_BITS_8N1=10 and FRAME_BITS_8E1=11;
  - constants TX_IDLE=1'b1 and TX_START=1'b0.
- One natural sub-module: uart_bit_timer. It holds the cycle counter, takes the parameter CLKS_PER_BIT, has inputs clear and enable, and has output tick at the bit boundary. It will be reused later by the receive-side block.

Test Plan (all scenarios use CLKS_PER_BIT=4):
- Reset mid-frame: push 0xA5, assert rst during DATA bit 3 → tx=1, busy=0 and fifo_rd=0 on the next edge; after release, no frame is sent while the FIFO is empty.
- Single byte: push 0xA5 with enable=1.
  - fifo_rd is high for exactly 1 cycle.
  - tx falls 3 cycles after fifo_empty=0 is first sampled in IDLE.
  - tx sequence is 0, then 1,0,1,0,0,1,0,1, then 1, with each bit held 4 cycles.
  - busy stays high for 42 cycles (REQ + LATCH + 40).
- Back-to-back: push 0x00, 0xFF, 0x3C → three frames in FIFO order. Each has its stop bit followed by 3 idle-high cycles before the next start bit. Exactly 3 fifo_rd pulses; fifo_empty is 1 at the end.
- enable gating: preload 2 bytes with enable=0 → tx stays 1 and fifo_rd stays 0 for 100 cycles. Raise enable, then drop it during the first frame's DATA → the first frame completes and the second byte remains in the FIFO.
- Parity (macro defined): send 0xA5 → parity bit is 0, frame is 44 cycles. Send 0x07 → parity bit is 1.
